phase_sequencer: RTL and testbench

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer_pkg.sv | 27 ++
 rtl/phase_sequencer.sv | 147 ++++++++++++++
 tb/tb_phase_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/phase_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// phase_sequencer_pkg
//   Shared typedefs and phase constants for the instruction phase sequencer.
//   seq_state_t   : sequencer operating state
//   FETCH_LAST_PH : last phase with the fetch/address-select phase active
//   ALU_PH        : the single phase that pulses the ALU clock
//   LAST_PH       : final phase of an instruction (the instruction boundary)
// -----------------------------------------------------------------------------
package phase_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_RUN    = 2'd1,
        SEQ_STEP   = 2'd2,
        SEQ_HALTED = 2'd3
    } seq_state_t;

    localparam logic [2:0] FETCH_LAST_PH = 3'd3;
    localparam logic [2:0] ALU_PH        = 3'd6;
    localparam logic [2:0] LAST_PH       = 3'd7;

    // RUN and STEP both walk the phase counter; the rest park it at 0.
    function automatic logic is_busy_state(input seq_state_t s);
        return (s == SEQ_RUN) || (s == SEQ_STEP);
    endfunction

endpackage

// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
//   Generates the eight-phase instruction cycle (fetch, controller clock, ALU
//   clock) for a small CPU, with run / single-step / stop control and a sticky
//   halt state.
//
//   Optional feature macro: SEQ_ICOUNT_EN -- adds the icount port, a wrapping
//   counter of completed instructions.
//
//   Ports
//     clk       in   system clock, all flops on the rising edge
//     rst_      in   asynchronous active-low reset
//     run       in   start free-running instruction cycles (from IDLE)
//     step      in   execute exactly one instruction (from IDLE, wins over run)
//     stop      in   stop at the next instruction boundary (RUN only)
//     halt      in   CPU halt flag, sampled at the instruction boundary
//     fetch     out  fetch/address-select phase (phases 0..3)
//     cntrl_clk out  controller clock (phase bit 0)
//     alu_clk   out  ALU clock (phase 6 only)
//     busy      out  high in RUN or STEP
//     halted    out  high in HALTED
//     icount    out  completed-instruction count (SEQ_ICOUNT_EN only)
// -----------------------------------------------------------------------------
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int ICOUNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic                run,
    input  logic                step,
    input  logic                stop,
    input  logic                halt,
    output logic                fetch,
    output logic                cntrl_clk,
    output logic                alu_clk,
    output logic                busy,
    output logic                halted
`ifdef SEQ_ICOUNT_EN
    ,
    output logic [ICOUNT_W-1:0] icount
`endif
);

    seq_state_t state, state_nxt;
    logic [2:0] phase, phase_nxt;
    logic       stop_pending, stop_pending_nxt;
    logic       fetch_nxt, cntrl_clk_nxt, alu_clk_nxt, busy_nxt, halted_nxt;

    // State register. The phase outputs are registered from the decode of the
    // *next* state/phase so they are glitch-free flop outputs and still line
    // up with the state change (fetch rises on the same edge that leaves IDLE).
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state        <= SEQ_IDLE;
            phase        <= 3'd0;
            stop_pending <= 1'b0;
            fetch        <= 1'b0;
            cntrl_clk    <= 1'b0;
            alu_clk      <= 1'b0;
            busy         <= 1'b0;
            halted       <= 1'b0;
        end else begin
            state        <= state_nxt;
            phase        <= phase_nxt;
            stop_pending <= stop_pending_nxt;
            fetch        <= fetch_nxt;
            cntrl_clk    <= cntrl_clk_nxt;
            alu_clk      <= alu_clk_nxt;
            busy         <= busy_nxt;
            halted       <= halted_nxt;
        end
    end

    // Next-state logic. Leaving RUN/STEP happens only when phase is LAST_PH,
    // so an instruction is never cut short by run/step/stop.
    always_comb begin
        state_nxt = state;
        phase_nxt = 3'd0;

        case (state)
            SEQ_IDLE: begin
                if (step) begin
                    state_nxt = SEQ_STEP;
                end else if (run) begin
                    state_nxt = SEQ_RUN;
                end
            end
            SEQ_RUN: begin
                if (phase == LAST_PH) begin
                    if (halt) begin
                        state_nxt = SEQ_HALTED;
                    end else if (stop_pending || stop) begin
                        state_nxt = SEQ_IDLE;
                    end
                end else begin
                    phase_nxt = phase + 3'd1;
                end
            end
            SEQ_STEP: begin
                if (phase == LAST_PH) begin
                    state_nxt = halt ? SEQ_HALTED : SEQ_IDLE;
                end else begin
                    phase_nxt = phase + 3'd1;
                end
            end
            default: begin
                state_nxt = SEQ_HALTED;
            end
        endcase

        // A stop request is only remembered while RUN continues; any exit from
        // RUN (to IDLE or HALTED) drops it, and stop is ignored in IDLE.
        if ((state == SEQ_RUN) && (state_nxt == SEQ_RUN)) begin
            stop_pending_nxt = stop_pending || stop;
        end else begin
            stop_pending_nxt = 1'b0;
        end
    end

    // Output decode of the upcoming state/phase, captured by the state register.
    always_comb begin
        busy_nxt      = is_busy_state(state_nxt);
        halted_nxt    = (state_nxt == SEQ_HALTED);
        fetch_nxt     = busy_nxt && (phase_nxt <= FETCH_LAST_PH);
        cntrl_clk_nxt = busy_nxt && phase_nxt[0];
        alu_clk_nxt   = busy_nxt && (phase_nxt == ALU_PH);
    end

`ifdef SEQ_ICOUNT_EN
    // Counts every instruction boundary, including the one that enters HALTED;
    // wraps naturally at all-ones.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            icount <= '0;
        end else if (is_busy_state(state) && (phase == LAST_PH)) begin
            icount <= icount + ICOUNT_W'(1);
        end
    end
`else
    // Counter width is only meaningful with the counter compiled in.
    if (ICOUNT_W < 1) begin : g_icount_w_unused
    end
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    logic run = 1'b0;
    logic step = 1'b0;
    logic stop = 1'b0;
    logic halt = 1'b0;
    logic fetch, cntrl_clk, alu_clk, busy, halted;
`ifdef SEQ_ICOUNT_EN
    logic [15:0] icount;
    logic [1:0]  icount2;
    logic        fetch2, cntrl_clk2, alu_clk2, busy2, halted2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    phase_sequencer #(.ICOUNT_W(16)) u_dut (
        .clk       (clk),
        .rst_      (rst_),
        .run       (run),
        .step      (step),
        .stop      (stop),
        .halt      (halt),
        .fetch     (fetch),
        .cntrl_clk (cntrl_clk),
        .alu_clk   (alu_clk),
        .busy      (busy),
        .halted    (halted)
`ifdef SEQ_ICOUNT_EN
        ,
        .icount    (icount)
`endif
    );

`ifdef SEQ_ICOUNT_EN
    phase_sequencer #(.ICOUNT_W(2)) u_dut2 (
        .clk       (clk),
        .rst_      (rst_),
        .run       (run),
        .step      (step),
        .stop      (stop),
        .halt      (halt),
        .fetch     (fetch2),
        .cntrl_clk (cntrl_clk2),
        .alu_clk   (alu_clk2),
        .busy      (busy2),
        .halted    (halted2),
        .icount    (icount2)
    );
`endif

    // {busy, halted, fetch, cntrl_clk, alu_clk} for phases 0..7 of one instruction
    logic [4:0] instr_exp [0:7] = '{5'b10100, 5'b10110, 5'b10100, 5'b10110,
                                    5'b10000, 5'b10010, 5'b10001, 5'b10010};
    logic [4:0] idle_exp   = 5'b00000;
    logic [4:0] halted_exp = 5'b01000;

    function automatic logic [4:0] obs();
        return {busy, halted, fetch, cntrl_clk, alu_clk};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        run = 1'b0; step = 1'b0; stop = 1'b0; halt = 1'b0;
        rst_ = 1'b0;
        tick(2);
        check("reset_outputs", 32'(obs()), 32'(idle_exp));
`ifdef SEQ_ICOUNT_EN
        check("reset_icount", 32'(icount), 32'd0);
`endif
        rst_ = 1'b1;
        tick(1);
    endtask

    initial begin
        // ---- single step: 8 busy clocks with the full phase decode ----
        do_reset();
        check("idle_after_reset", 32'(obs()), 32'(idle_exp));
        step = 1'b1;
        tick(1);
        step = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("step_ph%0d", k), 32'(obs()), 32'(instr_exp[k]));
            tick(1);
        end
        check("step_done_idle", 32'(obs()), 32'(idle_exp));
`ifdef SEQ_ICOUNT_EN
        check("step_icount", 32'(icount), 32'd1);
`endif
        tick(3);
        check("step_stays_idle", 32'(obs()), 32'(idle_exp));

        // ---- run, stop at phase 2 of third instruction ----
        do_reset();
        run = 1'b1;
        tick(1);
        run = 1'b0;
        check("run_ph0", 32'(obs()), 32'(instr_exp[0]));
        tick(8);
        check("run_instr2_ph0", 32'(obs()), 32'(instr_exp[0]));
        tick(8);
        tick(2);
        check("run_instr3_ph2", 32'(obs()), 32'(instr_exp[2]));
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("run_stop_ph3", 32'(obs()), 32'(instr_exp[3]));
        tick(4);
        check("run_stop_ph7", 32'(obs()), 32'(instr_exp[7]));
        tick(1);
        check("run_stop_idle", 32'(obs()), 32'(idle_exp));
`ifdef SEQ_ICOUNT_EN
        check("run_stop_icount", 32'(icount), 32'd3);
`endif

        // ---- run with halt during second instruction ----
        do_reset();
        run = 1'b1;
        tick(1);
        run = 1'b0;
        tick(8);
        halt = 1'b1;
        check("halt_instr2_ph0", 32'(obs()), 32'(instr_exp[0]));
        tick(7);
        check("halt_instr2_ph7", 32'(obs()), 32'(instr_exp[7]));
        tick(1);
        halt = 1'b0;
        check("halt_entered", 32'(obs()), 32'(halted_exp));
`ifdef SEQ_ICOUNT_EN
        check("halt_icount", 32'(icount), 32'd2);
`endif
        run = 1'b1;
        tick(1);
        run = 1'b0;
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(2);
        check("halt_sticky", 32'(obs()), 32'(halted_exp));

        // ---- run and step together: step wins ----
        do_reset();
        run = 1'b1;
        step = 1'b1;
        tick(1);
        run = 1'b0;
        step = 1'b0;
        check("both_ph0", 32'(obs()), 32'(instr_exp[0]));
        tick(7);
        check("both_ph7", 32'(obs()), 32'(instr_exp[7]));
        tick(1);
        check("both_idle", 32'(obs()), 32'(idle_exp));
`ifdef SEQ_ICOUNT_EN
        check("both_icount", 32'(icount), 32'd1);
`endif
        tick(8);
        check("both_stays_idle", 32'(obs()), 32'(idle_exp));

        // ---- asynchronous reset at phase 5 ----
        do_reset();
        run = 1'b1;
        tick(1);
        run = 1'b0;
        tick(5);
        check("areset_pre_ph5", 32'(obs()), 32'(instr_exp[5]));
        #2;
        rst_ = 1'b0;
        #1;
        check("areset_immediate", 32'(obs()), 32'(idle_exp));
`ifdef SEQ_ICOUNT_EN
        check("areset_icount", 32'(icount), 32'd0);
`endif
        tick(2);
        rst_ = 1'b1;
        tick(3);
        check("areset_idle_after", 32'(obs()), 32'(idle_exp));

`ifdef SEQ_ICOUNT_EN
        // ---- 2-bit counter wraps: 1, 2, 3, 0, 1 ----
        do_reset();
        begin
            logic [1:0] wrap_exp [0:4] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
            for (int s = 0; s < 5; s++) begin
                step = 1'b1;
                tick(1);
                step = 1'b0;
                tick(8);
                check($sformatf("wrap_step%0d", s), 32'(icount2), 32'(wrap_exp[s]));
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
